// File: rtl/lcd_spi_byte_tx.sv
// Mode-0, MSB-first byte serializer for the ST7789 LCD link. Build with
// LCD_SPI_BYTE_CNT_EN to add the byte_cnt debug output.
//
// Ports:
//   clk, rst_n                   12 MHz clock, async active-low reset
//   tx_valid/tx_ready            byte handshake from the sequencer
//   tx_data, tx_dc               byte and its data/command flag
//   busy                         high while lcd_cs is low
//   lcd_sclk/mosi/dc/cs          SPI pins to the LCD
//   byte_cnt                     accepted-byte count (optional)
module lcd_spi_byte_tx #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned CS_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  output logic       busy,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output logic       lcd_cs
`ifdef LCD_SPI_BYTE_CNT_EN
  ,
  output logic [15:0] byte_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    HOLD
  } state_e;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_INIT = 8'(CS_HOLD);

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        dc_q, dc_d;
  logic        accept;
  logic        load;

  assign tx_ready = (state_q == IDLE) || (state_q == HOLD);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    dc_d       = dc_q;
    load       = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = accept;
      end
      SHIFT_LO: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b1;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b0;
          if (bit_cnt_q != 3'd0) begin
            // next bit goes out on the falling edge
            bit_cnt_d = bit_cnt_q - 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            mosi_d    = shift_q[6];
            state_d   = SHIFT_LO;
          end else begin
            hold_cnt_d = HOLD_INIT;
            state_d    = HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // a new byte beats the cs release
        if (accept) begin
          load = 1'b1;
        end else if (hold_cnt_q <= 8'd1) begin
          hold_cnt_d = 8'd0;
          cs_d       = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d   = tx_data;
      dc_d      = tx_dc;
      cs_d      = 1'b0;
      busy_d    = 1'b1;
      mosi_d    = tx_data[7];
      bit_cnt_d = 3'd7;
      div_cnt_d = 8'd0;
      state_d   = SHIFT_LO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      div_cnt_q  <= 8'd0;
      hold_cnt_q <= 8'd0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      dc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      dc_q       <= dc_d;
    end
  end

  assign busy     = busy_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;
  assign lcd_dc   = dc_q;
  assign lcd_cs   = cs_q;

`ifdef LCD_SPI_BYTE_CNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (accept) byte_cnt_d = byte_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byte_cnt_q <= 16'd0;
    else        byte_cnt_q <= byte_cnt_d;
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// Directed bench for lcd_spi_byte_tx: one instance at CLK_DIV=1 and
// one at CLK_DIV=3, both CS_HOLD=2.
module tb_lcd_spi_byte_tx;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       v1, ready1, dc1, busy1, sclk1, mosi1, ldc1, cs1;
  logic [7:0] d1;
  logic       v3, ready3, dc3, busy3, sclk3, mosi3, ldc3, cs3;
  logic [7:0] d3;
`ifdef LCD_SPI_BYTE_CNT_EN
  logic [15:0] bc1, bc3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_spi_byte_tx #(.CLK_DIV(1), .CS_HOLD(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(v1), .tx_ready(ready1),
    .tx_data(d1), .tx_dc(dc1), .busy(busy1),
    .lcd_sclk(sclk1), .lcd_mosi(mosi1),
    .lcd_dc(ldc1), .lcd_cs(cs1)
`ifdef LCD_SPI_BYTE_CNT_EN
    , .byte_cnt(bc1)
`endif
  );

  lcd_spi_byte_tx #(.CLK_DIV(3), .CS_HOLD(2)) u3 (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(v3), .tx_ready(ready3),
    .tx_data(d3), .tx_dc(dc3), .busy(busy3),
    .lcd_sclk(sclk3), .lcd_mosi(mosi3),
    .lcd_dc(ldc3), .lcd_cs(cs3)
`ifdef LCD_SPI_BYTE_CNT_EN
    , .byte_cnt(bc3)
`endif
  );

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs,
                      input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // called right after the accept edge of a CLK_DIV=1 byte;
  // returns after the edge that enters HOLD
  task automatic collect1(input logic exp_dc,
                          output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk1("sclk_hi", sclk1, 1'b1);
      chk1("dc_const", ldc1, exp_dc);
      b = {b[6:0], mosi1};
      tick;
      chk1("sclk_lo", sclk1, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] b;
    int         acc;
    int         rises;
    logic       prev;
    logic       r;

    rst_n = 1'b0;
    v1 = 1'b0; d1 = 8'h00; dc1 = 1'b0;
    v3 = 1'b0; d3 = 8'h00; dc3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_cs", cs1, 1'b1);
    chk1("rst_sclk", sclk1, 1'b0);
    chk1("rst_mosi", mosi1, 1'b0);
    chk1("rst_dc", ldc1, 1'b0);
    chk1("rst_busy", busy1, 1'b0);
    chk1("rst_ready", ready1, 1'b1);
    rst_n = 1'b1;
    tick;

    // single byte A5, command
    d1 = 8'hA5; dc1 = 1'b0; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    chk1("t1_cs_low", cs1, 1'b0);
    chk1("t1_busy", busy1, 1'b1);
    chk1("t1_ready_low", ready1, 1'b0);
    chk1("t1_mosi_b7", mosi1, 1'b1);
    collect1(1'b0, b);
    chkb("t1_byte", b, 8'hA5);
    chk1("t1_hold_ready", ready1, 1'b1);
    chk1("t1_hold_cs", cs1, 1'b0);
    tick;
    chk1("t1_cs_17", cs1, 1'b0);
    tick;
    chk1("t1_cs_18", cs1, 1'b1);
    chk1("t1_busy_off", busy1, 1'b0);
    chk1("t1_ready_idle", ready1, 1'b1);

    // back-to-back 2A (cmd) then 00 (data)
    d1 = 8'h2A; dc1 = 1'b0; v1 = 1'b1;
    tick;
    d1 = 8'h00; dc1 = 1'b1;
    acc = 0;
    for (int k = 1; k <= 40; k++) begin
      r = ready1;
      tick;
      if (r) begin
        acc = k;
        break;
      end
      chk1("t2_cs_between", cs1, 1'b0);
    end
    v1 = 1'b0;
    chki("t2_accept_gap", acc, 17);
    chk1("t2_cs_kept", cs1, 1'b0);
    chk1("t2_dc_data", ldc1, 1'b1);
    chk1("t2_dc_sclk", sclk1, 1'b0);
    chk1("t2_mosi_b7", mosi1, 1'b0);
    collect1(1'b1, b);
    chkb("t2_byte2", b, 8'h00);
    tick;
    tick;
    chk1("t2_cs_release", cs1, 1'b1);

    // stall: 11 offered mid-byte
    d1 = 8'h96; dc1 = 1'b0; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    repeat (5) tick;
    d1 = 8'h11; dc1 = 1'b1; v1 = 1'b1;
    acc = 0;
    for (int k = 6; k <= 40; k++) begin
      r = ready1;
      tick;
      if (r) begin
        acc = k;
        break;
      end
    end
    v1 = 1'b0;
    chki("t3_accept_hold", acc, 17);
    collect1(1'b1, b);
    chkb("t3_byte", b, 8'h11);
    tick;
    tick;
    chk1("t3_no_dup", cs1, 1'b1);

    // divider: CLK_DIV=3, FF
    d3 = 8'hFF; dc3 = 1'b1; v3 = 1'b1;
    tick;
    v3 = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      tick;
      chk1("t4_sclk", sclk3, ((c / 3) % 2) == 1);
      if (sclk3 && !prev) rises++;
      prev = sclk3;
      if (c == 24) chk1("t4_mosi", mosi3, 1'b1);
      if (c == 47) chk1("t4_ready_47", ready3, 1'b0);
    end
    chki("t4_rises", rises, 8);
    chk1("t4_hold_48", ready3, 1'b1);
    chk1("t4_cs_48", cs3, 1'b0);
    repeat (3) tick;
    chk1("t4_cs_release", cs3, 1'b1);

    // reset mid-transfer
    d1 = 8'h55; dc1 = 1'b1; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    repeat (5) tick;
    chk1("t5_sclk_mid", sclk1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t5_cs", cs1, 1'b1);
    chk1("t5_sclk", sclk1, 1'b0);
    chk1("t5_mosi", mosi1, 1'b0);
    chk1("t5_dc", ldc1, 1'b0);
    chk1("t5_ready", ready1, 1'b1);
    chk1("t5_busy", busy1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    d1 = 8'h3C; dc1 = 1'b0; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    chk1("t5_cs_low", cs1, 1'b0);
    chk1("t5_mosi_b7", mosi1, 1'b0);
    collect1(1'b0, b);
    chkb("t5_byte", b, 8'h3C);
    tick;
    tick;
    chk1("t5_cs_release", cs1, 1'b1);

`ifdef LCD_SPI_BYTE_CNT_EN
    chki("t6_cnt_1", int'(bc1), 1);
    for (int i = 0; i < 2; i++) begin
      d1 = 8'h40 + 8'(i); dc1 = 1'b1; v1 = 1'b1;
      tick;
      v1 = 1'b0;
      repeat (18) tick;
    end
    chki("t6_cnt_3", int'(bc1), 3);
    force u1.byte_cnt_q = 16'hFFFF;
    #1;
    release u1.byte_cnt_q;
    chki("t6_preload", int'(bc1), 65535);
    d1 = 8'h77; dc1 = 1'b1; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    chki("t6_wrap", int'(bc1), 0);
    repeat (18) tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
